// File: rtl/fanin_rr_merge_if.sv
// Handshake bundle for the fan-in merge: NUM_IN producer streams in,
// one registered consumer stream out. The merge uses the slave view.
// The environment (producers plus consumer) uses the master view.
interface fanin_rr_merge_if #(
    parameter int NUM_IN = 7,
    parameter int DATA_W = 17
);
    localparam int SRC_W = $clog2(NUM_IN);

    // producer side
    logic [NUM_IN-1:0]        in_en;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_last;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_ready;

    // consumer side
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;

    modport slave (
        input  in_en, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

    modport master (
        output in_en, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/fanin_rr_merge.sv
// Fan-in merge: round-robin arbitration of NUM_IN valid/ready producers into
// a single-entry output register. With LOCK_PKT=1 a multi-beat packet holds
// the grant until its last beat transfers, so packets never interleave.
// The interface instance must carry the same NUM_IN/DATA_W as this module.
module fanin_rr_merge #(
    parameter int NUM_IN   = 7,
    parameter int DATA_W   = 17,
    parameter int LOCK_PKT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    fanin_rr_merge_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_IN);
    // Scan index is one bit wider so rr_ptr + offset cannot overflow before the wrap.
    localparam logic [SRC_W:0]   NUM_IN_X = (SRC_W+1)'(NUM_IN);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_IN - 1);

    typedef enum logic {
        ARB,
        LOCK
    } state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    lock_idx_q, lock_idx_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;

    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   grant;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_any;
    logic [SRC_W:0]      scan_idx;
    logic                load_ok;
    logic                xfer;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;

    // A disabled input never requests, so it is never granted.
    assign req     = bus.in_valid & bus.in_en;
    // The single output slot may be refilled when empty or being drained.
    assign load_ok = ~out_valid_q | bus.out_ready;

    // Pick the winner: the locked input only, or the first requester from rr_ptr onward.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        if (state_q == LOCK) begin
            grant_any = req[lock_idx_q];
            grant_idx = lock_idx_q;
        end else begin
            for (int off = 0; off < NUM_IN; off++) begin
                scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(off);
                if (scan_idx >= NUM_IN_X) begin
                    scan_idx = scan_idx - NUM_IN_X;
                end
                if (!grant_any && req[scan_idx[SRC_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx[SRC_W-1:0];
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign sel_data     = bus.in_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_last     = bus.in_last[grant_idx];
    assign xfer         = grant_any & load_ok & ~flush;
    assign bus.in_ready = grant & {NUM_IN{load_ok & ~flush}};

    // Next state of the output register, arbitration pointer and packet lock.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (flush) begin
            // In-flight beat is dropped; arbitration restarts from input 0.
            out_valid_d = 1'b0;
            state_d     = ARB;
            rr_ptr_d    = '0;
            lock_idx_d  = '0;
        end else if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);
            if (LOCK_PKT != 0 && !sel_last) begin
                state_d    = LOCK;
                lock_idx_d = grant_idx;
            end else begin
                state_d = ARB;
            end
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            // Locked producer was disabled mid-packet: release the lock.
            if (state_q == LOCK && !bus.in_en[lock_idx_q]) begin
                state_d = ARB;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_fanin_rr_merge.sv
// Directed bench for fanin_rr_merge. One instance with packet lock, one
// without, both driven by the same stimulus. Inputs change and outputs are
// sampled 1 time unit after the rising edge; combinational ready is sampled
// 1 further unit after an input change.
module tb_fanin_rr_merge;
    localparam int NUM_IN = 7;
    localparam int DATA_W = 17;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [NUM_IN-1:0]        in_en;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_last;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int bad;

    fanin_rr_merge_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();
    fanin_rr_merge_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus_nl ();

    assign bus.in_en        = in_en;
    assign bus.in_valid     = in_valid;
    assign bus.in_last      = in_last;
    assign bus.in_data      = in_data;
    assign bus.out_ready    = out_ready;
    assign bus_nl.in_en     = in_en;
    assign bus_nl.in_valid  = in_valid;
    assign bus_nl.in_last   = in_last;
    assign bus_nl.in_data   = in_data;
    assign bus_nl.out_ready = out_ready;

    fanin_rr_merge #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LOCK_PKT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    fanin_rr_merge #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LOCK_PKT(0)) dut_nl (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_nl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_d(input int i, input int v);
        in_data[i*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    // Compare the registered output of the locking instance.
    task automatic chk_out(input string tag, input logic v, input int src, input int data,
                           input logic last);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".src"},   32'(bus.out_src),   src);
        check({tag, ".data"},  32'(bus.out_data),  data);
        check({tag, ".last"},  32'(bus.out_last),  32'(last));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_en     = '1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        chk_out("rst", 1'b0, 0, 0, 1'b0);
        check("rst.ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        tick();

        // Round robin, every input valid with last=1, consumer always ready
        in_valid = '1;
        in_last  = '1;
        for (int i = 0; i < NUM_IN; i++) set_d(i, 'h10 + i);
        settle();
        check("rr.ready0", 32'(bus.in_ready), 32'h1);
        check("rr.nl_ready0", 32'(bus_nl.in_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out("rr", 1'b1, k % 7, 'h10 + (k % 7), 1'b1);
            check("rr.nl_src", 32'(bus_nl.out_src), k % 7);
            check("rr.ready", 32'(bus.in_ready), 1 << ((k + 1) % 7));
        end
        in_valid = '0;
        tick();
        chk_out("rr.drain", 1'b0, 0, 'h10, 1'b1);

        // Packet lock: input 2 sends 3 beats while input 5 waits (rr_ptr=1)
        in_valid = 7'b0100100;
        in_last  = 7'b0100000;
        set_d(2, 'h200);
        set_d(5, 'h500);
        settle();
        check("lock.ready0", 32'(bus.in_ready), 32'b0000100);
        tick();
        chk_out("lock.b0", 1'b1, 2, 'h200, 1'b0);
        set_d(2, 'h201);
        settle();
        check("lock.ready1", 32'(bus.in_ready), 32'b0000100);
        check("lock.nl_ready1", 32'(bus_nl.in_ready), 32'b0100000);
        tick();
        chk_out("lock.b1", 1'b1, 2, 'h201, 1'b0);
        check("lock.nl_src", 32'(bus_nl.out_src), 5);
        set_d(2, 'h202);
        in_last[2] = 1'b1;
        settle();
        check("lock.ready2", 32'(bus.in_ready), 32'b0000100);
        tick();
        chk_out("lock.b2", 1'b1, 2, 'h202, 1'b1);
        in_valid[2] = 1'b0;
        settle();
        check("lock.ready5", 32'(bus.in_ready), 32'b0100000);
        tick();
        chk_out("lock.i5", 1'b1, 5, 'h500, 1'b1);
        in_valid = '0;
        tick();
        check("lock.idle", 32'(bus.out_valid), 0);

        // Backpressure: 4 stalled cycles, producer 0 already advanced its data (rr_ptr=6)
        in_valid = 7'b0001001;
        in_last  = '1;
        set_d(0, 'hA0);
        set_d(3, 'hA3);
        settle();
        check("bp.ready0", 32'(bus.in_ready), 32'b0000001);
        tick();
        chk_out("bp.load", 1'b1, 0, 'hA0, 1'b1);
        set_d(0, 'hB0);
        out_ready = 1'b0;
        settle();
        check("bp.ready_stall", 32'(bus.in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("bp.hold", 1'b1, 0, 'hA0, 1'b1);
            check("bp.ready_hold", 32'(bus.in_ready), 0);
        end
        out_ready = 1'b1;
        settle();
        check("bp.ready3", 32'(bus.in_ready), 32'b0001000);
        tick();
        chk_out("bp.i3", 1'b1, 3, 'hA3, 1'b1);
        in_valid[3] = 1'b0;
        settle();
        check("bp.ready0b", 32'(bus.in_ready), 32'b0000001);
        tick();
        chk_out("bp.i0b", 1'b1, 0, 'hB0, 1'b1);
        in_valid = '0;
        tick();
        check("bp.idle", 32'(bus.out_valid), 0);

        // Disabled input 2 is never served (rr_ptr=1)
        in_en    = 7'b1111011;
        in_valid = 7'b0000100;
        set_d(2, 'h2EE);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.in_ready != '0 || bus.out_valid) bad++;
        end
        check("dis.bad_cycles", bad, 0);

        // Enable dropped on the locked input mid-packet
        in_en    = '1;
        in_valid = 7'b1010000;
        in_last  = 7'b1000000;
        set_d(4, 'h400);
        set_d(6, 'h666);
        settle();
        check("drop.ready0", 32'(bus.in_ready), 32'b0010000);
        tick();
        chk_out("drop.b0", 1'b1, 4, 'h400, 1'b0);
        set_d(4, 'h401);
        in_en[4] = 1'b0;
        settle();
        check("drop.ready_locked", 32'(bus.in_ready), 0);
        tick();
        check("drop.no_beat", 32'(bus.out_valid), 0);
        check("drop.ready6", 32'(bus.in_ready), 32'b1000000);
        tick();
        chk_out("drop.i6", 1'b1, 6, 'h666, 1'b1);
        in_valid = '0;
        in_en    = '1;
        tick();
        check("drop.idle", 32'(bus.out_valid), 0);

        // Flush while locked with out_valid=1 (rr_ptr=0)
        in_valid = 7'b0000100;
        in_last  = '1;
        set_d(2, 'h2AA);
        settle();
        check("fl.ready2", 32'(bus.in_ready), 32'b0000100);
        tick();
        in_valid = 7'b0010010;
        in_last  = 7'b0000010;
        set_d(1, 'h101);
        set_d(4, 'h4C0);
        settle();
        check("fl.ready4", 32'(bus.in_ready), 32'b0010000);
        tick();
        chk_out("fl.lock4", 1'b1, 4, 'h4C0, 1'b0);
        out_ready = 1'b0;
        flush     = 1'b1;
        settle();
        check("fl.ready_flush", 32'(bus.in_ready), 0);
        tick();
        check("fl.valid", 32'(bus.out_valid), 0);
        flush     = 1'b0;
        out_ready = 1'b1;
        settle();
        check("fl.ready_after", 32'(bus.in_ready), 32'b0000010);
        check("fl.nl_ready_after", 32'(bus_nl.in_ready), 32'b0000010);
        tick();
        chk_out("fl.i1", 1'b1, 1, 'h101, 1'b1);

        // Asynchronous reset mid-stream with out_valid=1
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst2", 1'b0, 0, 0, 1'b0);
        in_valid = 7'b1001001;
        in_last  = '1;
        set_d(0, 'hC0);
        tick();
        rst_n = 1'b1;
        settle();
        check("rst2.ready", 32'(bus.in_ready), 32'b0000001);
        tick();
        chk_out("rst2.i0", 1'b1, 0, 'hC0, 1'b1);
        in_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
